// File: rtl/nibble_serial_cmp_ctrl_if.sv
// nibble_serial_cmp_ctrl_if: operand and result handshake bundle for the
// nibble-serial compare sequencer.
// master = producer/consumer side, slave = sequencer side.
interface nibble_serial_cmp_ctrl_if #(
    parameter int unsigned NIBBLES = 4
);
    // Operand handshake
    logic                   in_valid;
    logic                   in_ready;
    logic [4*NIBBLES-1:0]   op_a;
    logic [4*NIBBLES-1:0]   op_b;

    // Result handshake
    logic                   out_valid;
    logic                   out_ready;
    logic                   gt;
    logic                   eq;
    logic                   lt;

    modport master (
        output in_valid,
        output op_a,
        output op_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  gt,
        input  eq,
        input  lt
    );

    modport slave (
        input  in_valid,
        input  op_a,
        input  op_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output gt,
        output eq,
        output lt
    );
endinterface

// File: rtl/nibble_serial_cmp_ctrl.sv
// nibble_serial_cmp_ctrl: compares two 4*NIBBLES-bit operands by streaming
// them MSB-nibble-first through an external 4-bit magnitude comparator,
// stopping at the first unequal nibble.
// Optional macro NSC_SIGNED_CMP_EN: treat operands as two's complement and
// resolve differing sign bits in the first RUN cycle without the comparator.
module nibble_serial_cmp_ctrl #(
    parameter int unsigned NIBBLES = 4,
    parameter int unsigned IDXW    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    nibble_serial_cmp_ctrl_if.slave     bus,
    output logic [3:0]                  cmp_a,
    output logic [3:0]                  cmp_b,
    input  logic                        cmp_gt,
    input  logic                        cmp_eq,
    input  logic                        cmp_lt,
    output logic                        busy
);
    localparam int unsigned W = 4 * NIBBLES;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NIBBLES - 1);

    logic [1:0]      state;
    logic [IDXW-1:0] idx;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            gt_r;
    logic            eq_r;
    logic            lt_r;

    logic [3:0]      nib_a;
    logic [3:0]      nib_b;
    logic            sign_split;
    logic            take_gt;
    logic            take_lt;
    logic            take_eq;

    // Select the nibble pair addressed by idx from the captured operands
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx == IDXW'(i)) begin
                nib_a = a_reg[4*i +: 4];
                nib_b = b_reg[4*i +: 4];
            end
        end
    end

    // Comparator inputs are only live during RUN, otherwise parked at zero
    always_comb begin
        cmp_a = (state == ST_RUN) ? nib_a : '0;
        cmp_b = (state == ST_RUN) ? nib_b : '0;
    end

    // Per-cycle decision: sign shortcut first, then gt > lt > eq priority;
    // a non-decisive cycle (eq or all-zero) with idx > 0 just moves on
    always_comb begin
`ifdef NSC_SIGNED_CMP_EN
        sign_split = (idx == IDX_TOP) && (a_reg[W-1] != b_reg[W-1]);
`else
        sign_split = 1'b0;
`endif
        take_gt = 1'b0;
        take_lt = 1'b0;
        take_eq = 1'b0;
        if (sign_split) begin
            take_gt = ~a_reg[W-1];
            take_lt =  a_reg[W-1];
        end else if (cmp_gt) begin
            take_gt = 1'b1;
        end else if (cmp_lt) begin
            take_lt = 1'b1;
        end else if (idx == '0) begin
            take_eq = 1'b1;
        end
    end

    // Sequencer state, operand capture, nibble index and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            gt_r  <= 1'b0;
            eq_r  <= 1'b0;
            lt_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.op_a;
                        b_reg <= bus.op_b;
                        idx   <= IDX_TOP;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (take_gt || take_lt || take_eq) begin
                        gt_r  <= take_gt;
                        eq_r  <= take_eq;
                        lt_r  <= take_lt;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake and status outputs decoded from the registered state
    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_DONE);
        bus.gt        = gt_r;
        bus.eq        = eq_r;
        bus.lt        = lt_r;
        busy          = (state == ST_RUN) || (state == ST_DONE);
    end
endmodule
